// File: rtl/flag_sequencer.sv
// Queues event requests and plays each one out as a single one-hot flag held for hold+1 cycles; first flag one edge after accept.
// Backpressure: in_ready drops when the request FIFO is full, judged on occupancy alone (a same-cycle pop does not free a slot).
module flag_sequencer #(
    parameter int FIFO_DEPTH = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_code,
    input  logic [3:0]       in_hold,
    output logic             a,
    output logic             b,
    output logic             c,
    output logic             d,
    output logic             busy,
    output logic [CNT_W-1:0] issued_cnt
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int OCC_W = PTR_W + 1;
    localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(FIFO_DEPTH);

    typedef struct packed {
        logic [1:0] code;
        logic [3:0] hold;
    } req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRIVE = 2'd1,
        GAP   = 2'd2
    } state_t;

    req_t             r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [OCC_W-1:0] r_occ;
    state_t           r_state;
    state_t           w_state_nxt;
    logic [3:0]       r_hold;
    logic [3:0]       w_hold_nxt;
    logic [3:0]       r_flags;
    logic [3:0]       w_flags_nxt;
    logic [CNT_W-1:0] r_issued;
    logic             w_push;
    logic             w_pop;
    logic             w_empty;
    req_t             w_head;
    req_t             w_in_req;

    assign in_ready = (r_occ != OCC_FULL);
    assign w_empty  = (r_occ == '0);
    assign w_push   = in_valid && in_ready;
    assign w_head   = r_mem[r_rd_ptr];
    assign w_in_req = '{code: in_code, hold: in_hold};

    // IDLE and GAP share the launch path; that is what makes back-to-back events one low cycle apart.
    always_comb begin
        w_state_nxt = r_state;
        w_hold_nxt  = r_hold;
        w_flags_nxt = r_flags;
        w_pop       = 1'b0;
        case (r_state)
            IDLE, GAP: begin
                if (w_empty) begin
                    w_state_nxt = IDLE;
                    w_flags_nxt = 4'b0000;
                end else begin
                    w_pop       = 1'b1;
                    w_hold_nxt  = w_head.hold;
                    w_flags_nxt = 4'b0001 << w_head.code;
                    w_state_nxt = DRIVE;
                end
            end
            DRIVE: begin
                if (r_hold == 4'd0) begin
                    w_flags_nxt = 4'b0000;
                    w_state_nxt = GAP;
                end else begin
                    w_hold_nxt = r_hold - 4'd1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_flags_nxt = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_hold   <= 4'd0;
            r_flags  <= 4'b0000;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
            r_issued <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_hold  <= w_hold_nxt;
            r_flags <= w_flags_nxt;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                r_issued <= r_issued + CNT_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_occ <= r_occ + OCC_W'(1);
                2'b01:   r_occ <= r_occ - OCC_W'(1);
                default: r_occ <= r_occ;
            endcase
        end
    end

    // Storage needs no reset: pointers and occupancy define what is valid.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_in_req;
        end
    end

    assign a          = r_flags[0];
    assign b          = r_flags[1];
    assign c          = r_flags[2];
    assign d          = r_flags[3];
    assign busy       = (r_state != IDLE) || !w_empty;
    assign issued_cnt = r_issued;

endmodule

// File: doc/flag_sequencer.md
FLAG_SEQUENCER -- requirements
Module: flag_sequencer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, number of queued event requests (power of two, >=2).
REQ-002 Parameter CNT_W, default 8, width of the issued-event counter.
REQ-003 clk  input  1  sole clock; all state updates on posedge clk.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on posedge clk.
REQ-005 in_valid  input  1  host presents an event request.
REQ-006 in_ready  output  1  block can accept a request this cycle.
REQ-007 in_code  input  2  event select: 0->a, 1->b, 2->c, 3->d.
REQ-008 in_hold  input  4  flag asserted for in_hold+1 cycles.
REQ-009 a, b, c, d  output  1 each  registered event flags, at most one high in any cycle.
REQ-010 busy  output  1  high while any request is queued or being driven.
REQ-011 issued_cnt  output  CNT_W  count of events started since reset.

Function
REQ-012 A request SHALL be accepted on a posedge where in_valid && in_ready, writing {in_code, in_hold} into the FIFO.
REQ-013 in_ready SHALL equal "FIFO not full", from the current occupancy only; a same-cycle pop SHALL NOT raise in_ready when full.
REQ-014 in_valid while in_ready is low SHALL be ignored, with no state change.
REQ-015 The FSM SHALL have states IDLE, DRIVE and GAP.
REQ-016 In IDLE with the FIFO non-empty, the FSM SHALL pop the head, load the hold counter with its hold value, register the selected flag high, and enter DRIVE.
REQ-017 In IDLE with the FIFO empty, the FSM SHALL stay in IDLE with all flags low.
REQ-018 In DRIVE, the selected flag SHALL stay high and the hold counter SHALL decrement each cycle.
REQ-019 When the hold counter reads 0 in DRIVE, the next cycle SHALL drive all flags low and enter GAP.
REQ-020 Each event SHALL therefore keep its flag high for exactly hold+1 consecutive cycles.
REQ-021 In GAP with the FIFO non-empty, the FSM SHALL pop and enter DRIVE as in REQ-016; otherwise it SHALL enter IDLE.
REQ-022 Back-to-back events SHALL be separated by exactly one all-low cycle.
REQ-023 Latency: a request accepted at edge N into an empty, idle block SHALL have its flag high after edge N+1.
REQ-024 A push and a pop in the same cycle SHALL both take effect, leaving occupancy unchanged.
REQ-025 FIFO pointers SHALL wrap modulo FIFO_DEPTH; occupancy SHALL range 0..FIFO_DEPTH.
REQ-026 Events SHALL be issued in acceptance order.
REQ-027 issued_cnt SHALL increment by 1 on every pop and wrap from 2^CNT_W-1 to 0.
REQ-028 busy SHALL equal (state != IDLE) || (FIFO occupancy != 0).
REQ-029 a/b/c/d SHALL never be high simultaneously, including across event boundaries.

Reset
REQ-030 On rst, the block SHALL set state to IDLE, empty the FIFO, and clear the hold counter.
REQ-031 After reset, a=b=c=d=0, busy=0, issued_cnt=0, and in_ready=1 SHALL hold from the first post-reset edge.
REQ-032 rst asserted mid-DRIVE SHALL drop the active flag on that edge and discard all queued requests.
REQ-033 rst SHALL take priority over a simultaneous push or pop.

Verification
REQ-034 Reset, then push {code=2, hold=0} at edge N -> c high for exactly 1 cycle after edge N+1; issued_cnt=1; busy low after GAP.
REQ-035 Push {0,3} then {3,1} back-to-back -> a high 4 cycles, 1 low cycle, d high 2 cycles; flags never overlap.
REQ-036 Push 4 requests while the first is driving -> in_ready low once occupancy=4; a 5th in_valid is ignored; all 4 events issue in order.
REQ-037 Hold in_valid with FIFO full while a pop occurs -> no accept that cycle; accept on the next cycle.
REQ-038 Assert rst during the 3rd cycle of {1,7} with 2 requests queued -> b low after that edge; no further flags; issued_cnt=0.
REQ-039 Issue 257 events with CNT_W=8 -> issued_cnt wraps to 1.
